// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int CLKS_PER_BIT_DEF = 10416;

  // $clog2 that never yields a zero-width vector
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_baud_counter.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = safe_clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Pops bytes from the sample FIFO and sends them as 8N1 UART frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | line high, pop and latch head byte when FIFO non-empty
// START  | start bit (tx=0)
// DATA   | payload bits, LSB first
// PARITY | even parity of payload (only with UART_TX_PARITY_EN)
// STOP   | STOP_BITS stop bits (tx=1)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DW           = 7,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [DW:0] fifo_rd_data,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy
);

  localparam int IW = safe_clog2(DW + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DW);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [DW:0]   shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          rd_req;
  logic          bit_done;
  logic          baud_clear;

  assign baud_clear = (state_q == IDLE);

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  // The shifter rotates so the latched byte (and its parity) survive the frame
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    rd_req  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          rd_req  = 1'b1;
          shift_d = fifo_rd_data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {shift_q[0], shift_q[DW:1]};
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (idx_q == LAST_STOP) state_d = IDLE;
          else                    idx_d   = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // A pop during reset would lose the byte without the state advancing
  assign fifo_rd = rd_req & ~reset;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a queue models the FIFO, a line decoder checks frames.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = (1 + 8 + PB + 1) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd, tx, busy;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         starts[$];
  int         n_chk = 0, n_fail = 0;
  int         rd_cnt = 0, viol = 0, frames = 0, cyc = 0;
  bit         mon_en = 1'b1, force_empty = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.DW(7), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic upd();
    fifo_empty   = force_empty || (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = fifo_rd;
    if (fifo_rd) begin
      rd_cnt++;
      if (fifo_empty || busy) viol++;
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    upd();
  endtask

  task automatic push(input logic [7:0] b, input bit expect_it);
    fifo_q.push_back(b);
    if (expect_it) exp_q.push_back(b);
    upd();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((busy || fifo_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < budget), 1);
    repeat (3) tick();
  endtask

  // Line decoder: expected bits come from the scoreboard byte, checked every cycle
  initial begin : mon
    logic       ptx, eb;
    logic [7:0] b;
    int         seg;
    ptx = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && ptx === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          b = 8'h00;
        end else begin
          b = exp_q.pop_front();
        end
        for (int c = 0; c < FL; c++) begin
          if (c > 0) @(negedge clk);
          seg = c / CPB;
          if (seg == 0)                 eb = 1'b0;
          else if (seg <= 8)            eb = b[seg-1];
          else if (PB == 1 && seg == 9) eb = ^b;
          else                          eb = 1'b1;
          check($sformatf("tx_byte%02h_seg%0d", b, seg), 32'(tx), 32'(eb));
          check("busy_in_frame", 32'(busy), 1);
        end
        @(negedge clk);
        check("gap_tx", 32'(tx), 1);
        check("gap_busy", 32'(busy), 0);
        frames++;
      end
      ptx = tx;
    end
  end

  initial begin : main
    int r0, n;
    reset = 1'b1;
    upd();
    repeat (3) begin
      tick();
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_rd", 32'(fifo_rd), 0);
    end
    reset = 1'b0;
    repeat (50) tick();
    check("idle_no_pop", rd_cnt, 0);
    check("idle_tx", 32'(tx), 1);

    // single byte with first-edge latency
    r0 = rd_cnt;
    push(8'hA5, 1'b1);
    tick();
    check("latency_tx", 32'(tx), 0);
    check("latency_busy", 32'(busy), 1);
    wait_drain(500);
    check("single_rd", rd_cnt - r0, 1);
    check("single_frames", frames, 1);

    // back-to-back frames
    r0 = rd_cnt;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    push(8'h3C, 1'b1);
    wait_drain(1000);
    check("b2b_rd", rd_cnt - r0, 3);
    check("b2b_frames", frames, 4);
    n = starts.size();
    if (n >= 3) begin
      check("b2b_gap_a", starts[n-2] - starts[n-3], FL + 1);
      check("b2b_gap_b", starts[n-1] - starts[n-2], FL + 1);
    end else begin
      check("b2b_starts", n, 4);
    end

    // reset in the middle of a frame; 0x55 is lost, 0x81 must follow intact
    mon_en = 1'b0;
    push(8'h55, 1'b0);
    push(8'h81, 1'b1);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("abort_start_seen", 32'(n < 20), 1);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    check("abort_tx", 32'(tx), 1);
    check("abort_busy", 32'(busy), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    wait_drain(500);
    check("abort_frames", frames, 5);

    // parity-relevant bytes
    push(8'h07, 1'b1);
    push(8'h03, 1'b1);
    wait_drain(500);
    check("parity_frames", frames, 7);

    // empty flag toggling while a frame is in progress
    r0 = rd_cnt;
    push(8'h5A, 1'b1);
    tick();
    push(8'hC3, 1'b1);
    repeat (20) begin
      force_empty = ~force_empty;
      upd();
      tick();
    end
    force_empty = 1'b0;
    upd();
    wait_drain(500);
    check("toggle_rd", rd_cnt - r0, 2);
    check("toggle_frames", frames, 9);

    check("rd_protocol", viol, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
